// File: rtl/sd_pkg.sv
// Shared sphere-decoder types and defaults: widths, FSM encoding, symbol vector.
package sd_pkg;
    localparam int WIDTH   = 32;
    localparam int SYM_W   = 3;
    localparam int NUM_ANT = 4;
    localparam int CNT_W   = 16;

    localparam logic [WIDTH-1:0] INIT_RADIUS = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2
    } sd_state_t;

    // Entry k holds the symbol index for antenna k (S_k).
    typedef logic [NUM_ANT-1:0][SYM_W-1:0] sym_vec_t;
endpackage

// File: rtl/sd_best_leaf_tracker_if.sv
// Node stream in, radius/prune feedback out, detection result with valid/ready.
interface sd_best_leaf_tracker_if #(
    parameter int WIDTH = sd_pkg::WIDTH,
    parameter int SYM_W = sd_pkg::SYM_W,
    parameter int CNT_W = sd_pkg::CNT_W
);
    logic             start;
    logic             node_valid;
    logic [1:0]       node_lvl;
    logic [WIDTH-1:0] node_cost;
    logic [SYM_W-1:0] s_0, s_1, s_2, s_3;
    logic             search_done;
    logic [WIDTH-1:0] radius;
    logic             prune;
    logic [SYM_W-1:0] det_0, det_1, det_2, det_3;
    logic [WIDTH-1:0] det_cost;
    logic             det_no_hit;
    logic             det_valid;
    logic             det_ready;
    logic [CNT_W-1:0] leaf_count;
    logic             busy;

    modport master (
        output start, node_valid, node_lvl, node_cost, s_0, s_1, s_2, s_3,
               search_done, det_ready,
        input  radius, prune, det_0, det_1, det_2, det_3, det_cost,
               det_no_hit, det_valid, leaf_count, busy
    );

    modport slave (
        input  start, node_valid, node_lvl, node_cost, s_0, s_1, s_2, s_3,
               search_done, det_ready,
        output radius, prune, det_0, det_1, det_2, det_3, det_cost,
               det_no_hit, det_valid, leaf_count, busy
    );
endinterface

// File: rtl/sd_min_select.sv
// Strict-less compare of a candidate against the incumbent, muxing {cost, symbols}.
module sd_min_select #(
    parameter int WIDTH   = sd_pkg::WIDTH,
    parameter int SYM_W   = sd_pkg::SYM_W,
    parameter int NUM_ANT = sd_pkg::NUM_ANT
) (
    input  logic                            cand_vld,
    input  logic [WIDTH-1:0]                cand_cost,
    input  logic [NUM_ANT-1:0][SYM_W-1:0]   cand_sym,
    input  logic [WIDTH-1:0]                best_cost,
    input  logic [NUM_ANT-1:0][SYM_W-1:0]   best_sym,
    output logic                            take,
    output logic [WIDTH-1:0]                nxt_cost,
    output logic [NUM_ANT-1:0][SYM_W-1:0]   nxt_sym
);
    // Strict compare: on a tie the incumbent (earlier leaf) survives.
    assign take     = cand_vld && (cand_cost < best_cost);
    assign nxt_cost = take ? cand_cost : best_cost;
    assign nxt_sym  = take ? cand_sym  : best_sym;
endmodule

// File: rtl/sd_best_leaf_tracker.sv
// Tracks the minimum-cost leaf of a sphere-decoder search, feeds the radius back
// upstream and presents the detected symbol vector through a valid/ready handshake.
module sd_best_leaf_tracker
    import sd_pkg::*;
#(
    parameter int               WIDTH       = sd_pkg::WIDTH,
    parameter int               SYM_W       = sd_pkg::SYM_W,
    parameter int               CNT_W       = sd_pkg::CNT_W,
    parameter logic [WIDTH-1:0] INIT_RADIUS = {WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    sd_best_leaf_tracker_if.slave  bus
);
    typedef logic [NUM_ANT-1:0][SYM_W-1:0] svec_t;

    sd_state_t        state;
    logic [WIDTH-1:0] radius_q;
    svec_t            best_q;
    logic             found_q;
    svec_t            det_q;
    logic [WIDTH-1:0] det_cost_q;
    logic             det_no_hit_q;
    logic             det_valid_q;
    logic [CNT_W-1:0] leaf_cnt_q;

    logic             leaf;
    logic             take;
    logic [WIDTH-1:0] nxt_cost;
    svec_t            nxt_sym;
    svec_t            cand_sym;
    logic             restart;

    assign leaf     = bus.node_valid && (bus.node_lvl == 2'd0);
    assign cand_sym = {bus.s_3, bus.s_2, bus.s_1, bus.s_0};

    sd_min_select #(.WIDTH(WIDTH), .SYM_W(SYM_W), .NUM_ANT(NUM_ANT)) u_min (
        .cand_vld  (leaf),
        .cand_cost (bus.node_cost),
        .cand_sym  (cand_sym),
        .best_cost (radius_q),
        .best_sym  (best_q),
        .take      (take),
        .nxt_cost  (nxt_cost),
        .nxt_sym   (nxt_sym)
    );

    // In HOLD a Start only counts when the pending result is taken the same cycle.
    assign restart = bus.start &&
                     ((state == IDLE) || (state == SEARCH) ||
                      ((state == HOLD) && bus.det_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            radius_q     <= INIT_RADIUS;
            best_q       <= '0;
            found_q      <= 1'b0;
            det_q        <= '0;
            det_cost_q   <= '0;
            det_no_hit_q <= 1'b0;
            det_valid_q  <= 1'b0;
            leaf_cnt_q   <= '0;
        end else begin
            if ((state == HOLD) && bus.det_ready) begin
                det_valid_q <= 1'b0;
                state       <= IDLE;
            end
            if (restart) begin
                state      <= SEARCH;
                radius_q   <= INIT_RADIUS;
                best_q     <= '0;
                found_q    <= 1'b0;
                leaf_cnt_q <= '0;
            end else if (state == SEARCH) begin
                if (leaf && (leaf_cnt_q != {CNT_W{1'b1}}))
                    leaf_cnt_q <= leaf_cnt_q + CNT_W'(1);
                if (take) begin
                    radius_q <= nxt_cost;
                    best_q   <= nxt_sym;
                    found_q  <= 1'b1;
                end
                // A leaf coincident with SearchDone is folded in via nxt_*.
                if (bus.search_done) begin
                    state        <= HOLD;
                    det_valid_q  <= 1'b1;
                    det_no_hit_q <= ~(found_q | take);
                    det_q        <= (found_q | take) ? nxt_sym  : '0;
                    det_cost_q   <= (found_q | take) ? nxt_cost : INIT_RADIUS;
                end
            end
        end
    end

    assign bus.radius     = radius_q;
    assign bus.prune      = (state == SEARCH) && bus.node_valid && (bus.node_cost >= radius_q);
    assign bus.busy       = (state == SEARCH);
    assign bus.det_0      = det_q[0];
    assign bus.det_1      = det_q[1];
    assign bus.det_2      = det_q[2];
    assign bus.det_3      = det_q[3];
    assign bus.det_cost   = det_cost_q;
    assign bus.det_no_hit = det_no_hit_q;
    assign bus.det_valid  = det_valid_q;
    assign bus.leaf_count = leaf_cnt_q;
endmodule

// File: doc/sd_best_leaf_tracker.md
Name: sd_best_leaf_tracker

Overview:
- Stage directly downstream of metric_calc in the sphere decoder.
- Per cycle, consumes the enumerated node (level, accumulated cost, candidate symbols S_0..S_3) and tracks the minimum-cost leaf (level 0).
- Feeds the running best cost back upstream as the sphere radius and a prune flag.
- At end of search, presents the detected 4-symbol vector with a valid/ready handshake.

Parameters:
- WIDTH, 32, bit width of node cost and radius (unsigned).
- SYM_W, 3, bits per symbol index (8-point constellation).
- CNT_W, 16, leaf-counter width.
- INIT_RADIUS, {WIDTH{1'b1}}, radius loaded on Start.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle pulse; begins a new search.
- NodeValid  in  1  node inputs are valid this cycle.
- NodeLvl  in  2  tree level of the current node; 0 = leaf.
- NodeCost  in  WIDTH  accumulated metric of the current node.
- S_0, S_1, S_2, S_3  in  SYM_W each  candidate symbol indices.
- SearchDone  in  1  pulse from the enumerator; search exhausted.
- Radius  out  WIDTH  current best leaf cost (sphere radius).
- Prune  out  1  current node's cost is at or above the radius.
- Det_0, Det_1, Det_2, Det_3  out  SYM_W each  detected symbols.
- DetCost  out  WIDTH  cost of the detected leaf.
- DetNoHit  out  1  search ended with no leaf accepted.
- DetValid  out  1  detection result available.
- DetReady  in  1  consumer accepts the result.
- LeafCount  out  CNT_W  number of valid leaves seen in this search.
- Busy  out  1  high in SEARCH.

Behaviour:
- Reset (async, Reset=1):
  - State=IDLE; Radius=INIT_RADIUS.
  - Det_*=0, DetCost=0, DetNoHit=0, DetValid=0, LeafCount=0, Busy=0.
  - Internal found flag cleared.
  - Asserting Reset mid-search aborts the search with no output.
- States: IDLE, SEARCH, HOLD.
- IDLE:
  - Start → SEARCH next cycle.
  - Same edge: Radius←INIT_RADIUS, LeafCount←0, found←0, best registers←0.
  - All node inputs are ignored.
- SEARCH:
  - Leaf event = NodeValid && NodeLvl==0.
  - On a leaf event, LeafCount increments and saturates at all-ones.
  - On a leaf event with NodeCost < Radius (strict, unsigned):
    - best symbols←S_0..S_3, Radius←NodeCost, found←1.
    - Ties keep the earlier leaf.
  - Non-leaf nodes never update state.
  - Start in SEARCH restarts the search: reinitialise exactly as in IDLE; any same-cycle leaf is discarded.
  - SearchDone → HOLD.
    - A leaf arriving in the same cycle as SearchDone is compared first and is included in the result.
    - On that edge: DetValid←1, Det_*←final best, DetCost←final best cost, DetNoHit←~found.
    - Latency from SearchDone to DetValid is 1 cycle.
    - If DetNoHit=1: Det_*=0 and DetCost=INIT_RADIUS.
- HOLD:
  - Det_*, DetCost, DetNoHit and DetValid are held stable while DetReady=0.
  - DetValid && DetReady → DetValid←0, go to IDLE.
  - If Start coincides with DetReady, go straight to SEARCH with reinitialisation.
  - Start without DetReady is ignored; no result is ever dropped.
  - NodeValid and SearchDone are ignored.
- Prune (combinational):
  - Prune = (state==SEARCH) && NodeValid && (NodeCost >= Radius).
  - Uses the registered Radius, not a same-cycle update.
  - Applies to every level, so upstream may skip subtrees.
- Radius is registered and holds its value through HOLD and IDLE until the next Start.
- Busy = (state==SEARCH).
- Arithmetic: unsigned comparison only; no adders on the cost path except the LeafCount increment.

Decomposition:
- Shared package sd_pkg holds:
  - WIDTH default, SYM_W=3, NUM_ANT=4, CNT_W.
  - State encoding constants (IDLE=0, SEARCH=1, HOLD=2).
  - INIT_RADIUS.
  - A symbol-vector typedef of NUM_ANT × SYM_W.
- One sub-module: sd_min_select.
  - Combinational strict-less compare plus 2:1 mux of {cost, symbols}.
  - Reused later by the K-best variant.
- The state machine and counters stay in the top block.

Test Plan:
- Reset behaviour: Reset=1 at t=1, released; then Start, leaves cost 500/300/300, SearchDone, DetReady=1 → Radius=300; Det = second leaf's symbols (tie keeps earlier); DetValid high exactly 1 cycle after SearchDone; LeafCount=3.
- Exhaustive-order stream: 4096 leaves ending with the minimum (cost 1234) on symbols 4,1,2,7, with non-leaf nodes interleaved → Det=4,1,2,7, DetCost=1234, DetNoHit=0; non-leaf nodes never change Radius.
- Prune: after best=1000, node cost 1000 → Prune=1; cost 999 → Prune=0; cost 5 at NodeLvl=2 → Prune=0 and Radius unchanged.
- No hit: Start, only level-1..3 nodes, SearchDone → DetNoHit=1, Det_*=0, DetCost=INIT_RADIUS, LeafCount=0.
- Handshake and coincident events:
  - Hold DetReady=0 for 10 cycles → outputs stable and Start ignored.
  - Then DetReady=1 together with Start → DetValid falls, next state SEARCH, Radius=INIT_RADIUS.
  - Leaf of cost 7 in the same cycle as SearchDone → DetCost=7.
- Mid-operation reset and restart:
  - Reset mid-search → all outputs return to reset values immediately (asynchronous).
  - Start mid-search → LeafCount=0, Radius=INIT_RADIUS on the next cycle.
